// File: rtl/spi_interface.sv
// spi_interface -- SPI-style slave with an internal 256x8 RAM.
//
// Frame format: 10 bits, MSB first, captured on rising clk while SS_n is low.
//   din[9:8] = 00  load write address      (wr_addr <= din[7:0])
//   din[9:8] = 01  write data              (RAM1[wr_addr] <= din[7:0])
//   din[9:8] = 10  load read address       (rd_addr <= din[7:0], rd_addr_flag set)
//   din[9:8] = 11  read data               (RAM1[rd_addr] shifted out on MISO)
//
// Ports (spi_interface):
//   MOSI  in   serial data from master
//   clk   in   sole clock, rising edge
//   SS_n  in   active-low slave select; high aborts any frame
//   rst   in   synchronous active-high reset
//   MISO  out  registered serial read data, 0 when idle
//
// Build option: define SPI_ADDR_AUTOINC_EN to make wr_addr advance after each
// data write and rd_addr advance after each data read (mod 256); in that build a
// read keeps rd_addr_flag set so back-to-back reads stream consecutive bytes.

// Single-port RAM plus the address registers it acts on.
//   clk, rst      clock and synchronous reset (RAM1 itself is never reset)
//   din[9:0]      completed frame, valid while rx_valid is high
//   rx_valid      one-cycle strobe for a complete frame
//   dout[7:0]     byte read by a cmd-11 frame
//   tx_valid      one-cycle strobe, dout has just been loaded
//   rd_addr_flag  a read address has been loaded and not yet consumed
module spi_ram (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] din,
   input  logic       rx_valid,
   output logic [7:0] dout,
   output logic       tx_valid,
   output logic       rd_addr_flag
);

   logic [7:0] RAM1 [0:255];
   logic [7:0] wr_addr;
   logic [7:0] rd_addr;

   // Kept apart from the reset block so the array maps onto a plain RAM.
   always_ff @(posedge clk) begin
      if (!rst && rx_valid && din[9:8] == 2'b01)
         RAM1[wr_addr] <= din[7:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_addr      <= 8'h00;
         rd_addr      <= 8'h00;
         rd_addr_flag <= 1'b0;
         dout         <= 8'h00;
         tx_valid     <= 1'b0;
      end else begin
         tx_valid <= 1'b0;
         if (rx_valid) begin
            case (din[9:8])
               2'b00: wr_addr <= din[7:0];
               2'b01: begin
`ifdef SPI_ADDR_AUTOINC_EN
                  wr_addr <= wr_addr + 8'd1;
`endif
               end
               2'b10: begin
                  rd_addr      <= din[7:0];
                  rd_addr_flag <= 1'b1;
               end
               default: begin
                  dout     <= RAM1[rd_addr];
                  tx_valid <= 1'b1;
`ifdef SPI_ADDR_AUTOINC_EN
                  rd_addr  <= rd_addr + 8'd1;
`else
                  rd_addr_flag <= 1'b0;
`endif
               end
            endcase
         end
      end
   end

endmodule

// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for SS_n low
// CHK_CMD   | capture frame bit 9, pick write / read-address / read-data
// WRITE     | shift bits 8..0 of a write-type frame (cmd 00 or 01)
// READ_ADD  | shift bits 8..0, no read address pending (no MISO output)
// READ_DATA | shift bits 8..0, read address pending; serialize cmd-11 data
module spi_interface (
   input  logic MOSI,
   input  logic clk,
   input  logic SS_n,
   input  logic rst,
   output logic MISO
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CHK_CMD   = 3'd1,
      WRITE     = 3'd2,
      READ_ADD  = 3'd3,
      READ_DATA = 3'd4
   } state_t;

   state_t     state;
   logic [9:0] din;
   logic [3:0] bit_cnt;      // frame bits still to shift after bit 9
   logic       rx_valid;
   logic       ser_active;
   logic [2:0] ser_idx;      // next dout bit to drive while serializing
   logic [7:0] dout;
   logic       tx_valid;
   logic       rd_addr_flag;

   spi_ram RAM (
      .clk          (clk),
      .rst          (rst),
      .din          (din),
      .rx_valid     (rx_valid),
      .dout         (dout),
      .tx_valid     (tx_valid),
      .rd_addr_flag (rd_addr_flag)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         din        <= 10'd0;
         bit_cnt    <= 4'd0;
         rx_valid   <= 1'b0;
         ser_active <= 1'b0;
         ser_idx    <= 3'd0;
         MISO       <= 1'b0;
      end else if (SS_n) begin
         // Deselect discards any partial frame and stops serialization.
         state      <= IDLE;
         bit_cnt    <= 4'd0;
         rx_valid   <= 1'b0;
         ser_active <= 1'b0;
         MISO       <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         case (state)
            IDLE: state <= CHK_CMD;
            CHK_CMD: begin
               din     <= {9'd0, MOSI};
               bit_cnt <= 4'd9;
               if (!MOSI)
                  state <= WRITE;
               else if (rd_addr_flag)
                  state <= READ_DATA;
               else
                  state <= READ_ADD;
            end
            WRITE, READ_ADD, READ_DATA: begin
               // Once bit_cnt reaches 0, further MOSI bits are ignored until deselect.
               if (bit_cnt != 4'd0) begin
                  din     <= {din[8:0], MOSI};
                  bit_cnt <= bit_cnt - 4'd1;
                  if (bit_cnt == 4'd1)
                     rx_valid <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase

         // tx_valid in READ_ADD yields no output: only READ_DATA frames serialize.
         if (ser_active) begin
            MISO <= dout[ser_idx];
            if (ser_idx == 3'd0)
               ser_active <= 1'b0;
            else
               ser_idx <= ser_idx - 3'd1;
         end else if (tx_valid && state == READ_DATA) begin
            MISO       <= dout[7];
            ser_active <= 1'b1;
            ser_idx    <= 3'd6;
         end else begin
            MISO <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_spi_interface.sv
module tb_spi_interface;

   logic clk = 1'b0;
   logic rst;
   logic MOSI;
   logic SS_n;
   logic MISO;

   localparam logic [2:0] S_IDLE = 3'd0, S_CHK = 3'd1, S_WR = 3'd2,
                          S_RADD = 3'd3, S_RDAT = 3'd4;

   int total = 0;
   int bad   = 0;

   logic sb[$];

   typedef struct {
      logic [9:0] frame;
      logic       rd;
      logic [7:0] byte_exp;
      logic [2:0] st_exp;
   } vec_t;

   vec_t vecs[8];

   spi_interface dut (
      .MOSI (MOSI),
      .clk  (clk),
      .SS_n (SS_n),
      .rst  (rst),
      .MISO (MISO)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Full frame with SS_n held low 19 cycles after CHK_CMD entry; MISO is
   // compared each cycle against the scoreboard (0 when nothing is queued).
   task automatic run_frame(input logic [9:0] f, output logic [2:0] st_cmd);
      logic e;
      @(negedge clk);
      SS_n = 1'b0;
      MOSI = 1'($urandom_range(0, 1));
      st_cmd = S_IDLE;
      for (int i = 9; i >= 0; i--) begin
         @(negedge clk);
         if (i == 8) st_cmd = dut.state;
         MOSI = f[i];
      end
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         e = 1'b0;
         if (k >= 2 && sb.size() > 0) e = sb.pop_front();
         check($sformatf("miso f=%h k=%0d", f, k), {7'd0, MISO}, {7'd0, e});
         MOSI = 1'($urandom_range(0, 1));
      end
      SS_n = 1'b1;
      @(negedge clk);
      check("miso_after_deselect", {7'd0, MISO}, 8'h00);
   endtask

   task automatic push_byte(input logic [7:0] b);
      for (int j = 7; j >= 0; j--) sb.push_back(b[j]);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst  = 1'b1;
      SS_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [2:0] st;
      logic [7:0] snap3b, snap3d;

      rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0;
      do_reset();
      check("rst_miso",    {7'd0, MISO}, 8'h00);
      check("rst_state",   {5'd0, dut.state}, {5'd0, S_IDLE});
      check("rst_wr_addr", dut.RAM.wr_addr, 8'h00);
      check("rst_rd_addr", dut.RAM.rd_addr, 8'h00);
      check("rst_flag",    {7'd0, dut.RAM.rd_addr_flag}, 8'h00);

      // Read command with no read address loaded: READ_ADD path, silent MISO.
      run_frame(10'h300, st);
      check("noaddr_read_path", {5'd0, st}, {5'd0, S_RADD});

      snap3b = dut.RAM.RAM1[8'h3B];
      snap3d = dut.RAM.RAM1[8'h3D];

      vecs[0] = '{10'h03C, 1'b0, 8'h00, S_WR};
      vecs[1] = '{10'h1A5, 1'b0, 8'h00, S_WR};
      vecs[2] = '{10'h010, 1'b0, 8'h00, S_WR};
      vecs[3] = '{10'h15A, 1'b0, 8'h00, S_WR};
      vecs[4] = '{10'h210, 1'b0, 8'h00, S_RADD};
      vecs[5] = '{10'h300, 1'b1, 8'h5A, S_RDAT};
`ifdef SPI_ADDR_AUTOINC_EN
      vecs[6] = '{10'h23C, 1'b0, 8'h00, S_RDAT};
`else
      vecs[6] = '{10'h23C, 1'b0, 8'h00, S_RADD};
`endif
      vecs[7] = '{10'h3FF, 1'b1, 8'hA5, S_RDAT};

      for (int v = 0; v < 8; v++) begin
         if (vecs[v].rd) push_byte(vecs[v].byte_exp);
         run_frame(vecs[v].frame, st);
         check($sformatf("path v%0d", v), {5'd0, st}, {5'd0, vecs[v].st_exp});
      end
      check("ram_3c", dut.RAM.RAM1[8'h3C], 8'hA5);
      check("ram_10", dut.RAM.RAM1[8'h10], 8'h5A);
      check("ram_3d_untouched", dut.RAM.RAM1[8'h3D], snap3d);

      // Deselect after 5 bits of 01_FF: no write, next frame still decodes.
      run_frame(10'h03B, st);
      @(negedge clk);
      SS_n = 1'b0;
      for (int i = 9; i >= 5; i--) begin
         @(negedge clk);
         MOSI = (i == 9) ? 1'b0 : 1'b1;
      end
      @(negedge clk);
      SS_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("abort_no_write", dut.RAM.RAM1[8'h3B], snap3b);
      check("abort_miso", {7'd0, MISO}, 8'h00);
      run_frame(10'h177, st);
      check("after_abort_write", dut.RAM.RAM1[8'h3B], 8'h77);

      // Reset in the middle of a 01_EE frame.
      @(negedge clk);
      SS_n = 1'b0;
      for (int i = 9; i >= 3; i--) begin
         @(negedge clk);
         MOSI = (i == 9) ? 1'b0 : ((10'h1EE >> i) & 10'h1) != 0;
      end
      do_reset();
      @(negedge clk);
      @(negedge clk);
      check("midrst_ram_3b", dut.RAM.RAM1[8'h3B], 8'h77);
      check("midrst_ram_3c", dut.RAM.RAM1[8'h3C], 8'hA5);
      check("midrst_wr_addr", dut.RAM.wr_addr, 8'h00);
      check("midrst_state", {5'd0, dut.state}, {5'd0, S_IDLE});

      // Address wrap: 0xFF then two data writes, then two reads from 0xFF.
      run_frame(10'h0FF, st);
      run_frame(10'h111, st);
      run_frame(10'h122, st);
      run_frame(10'h2FF, st);
`ifdef SPI_ADDR_AUTOINC_EN
      check("wrap_ram_ff", dut.RAM.RAM1[8'hFF], 8'h11);
      check("wrap_ram_00", dut.RAM.RAM1[8'h00], 8'h22);
      push_byte(8'h11);
      run_frame(10'h300, st);
      check("wrap_rd1_path", {5'd0, st}, {5'd0, S_RDAT});
      push_byte(8'h22);
      run_frame(10'h300, st);
      check("wrap_rd2_path", {5'd0, st}, {5'd0, S_RDAT});
      check("wrap_rd_addr", dut.RAM.rd_addr, 8'h01);
`else
      check("wrap_ram_ff", dut.RAM.RAM1[8'hFF], 8'h22);
      check("wrap_wr_addr", dut.RAM.wr_addr, 8'hFF);
      push_byte(8'h22);
      run_frame(10'h300, st);
      check("wrap_rd1_path", {5'd0, st}, {5'd0, S_RDAT});
      run_frame(10'h300, st);
      check("wrap_rd2_path", {5'd0, st}, {5'd0, S_RADD});
      check("wrap_rd_addr", dut.RAM.rd_addr, 8'hFF);
`endif

      check("scoreboard_empty", sb.size(), 8'h00);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spi_interface.md
SPI_INTERFACE -- requirements
Module: spi_interface

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 MOSI  input  1  serial data from master, sampled on rising clk.
REQ-004 SS_n  input  1  active-low slave select; high ends/aborts any frame.
REQ-005 MISO  output  1  serial read data to master, registered.
REQ-006 Positional port order: MOSI, clk, SS_n, rst, MISO.
REQ-007 Internal 256x8 single-port RAM instance named RAM, array named RAM1, hierarchically loadable by benches.

Function
REQ-008 FSM states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
REQ-009 IDLE -> CHK_CMD when SS_n=0 sampled; else stay.
REQ-010 CHK_CMD samples MOSI as frame bit 9: 0 -> WRITE; 1 and rd_addr_flag=0 -> READ_ADD; 1 and rd_addr_flag=1 -> READ_DATA.
REQ-011 WRITE/READ_ADD/READ_DATA shift 9 further MOSI bits MSB-first into din[8:0], giving 10-bit frame din[9:0].
REQ-012 On the edge capturing bit 0, rx_valid pulses one cycle; RAM acts on din[9:8] at the next edge.
REQ-013 din[9:8]=00: wr_addr <= din[7:0].
REQ-014 din[9:8]=01: RAM1[wr_addr] <= din[7:0].
REQ-015 din[9:8]=10: rd_addr <= din[7:0]; rd_addr_flag <= 1.
REQ-016 din[9:8]=11: dout <= RAM1[rd_addr]; tx_valid pulses; rd_addr_flag <= 0.
REQ-017 In READ_DATA with cmd 11, slave drives dout[7]..dout[0] on MISO on 8 consecutive edges starting with the edge after tx_valid; master keeps SS_n low 19 cycles after CHK_CMD entry.
REQ-018 MISO = 0 whenever not serializing.
REQ-019 SS_n=1 in any state -> IDLE next edge; partial frame discarded, no RAM access, serialization aborted, MISO=0.
REQ-020 Extra MOSI bits after bit 0 while SS_n low are ignored until SS_n returns high.
REQ-021 Cmd 11 received in READ_ADD state still reads RAM but produces no MISO output.

Reset
REQ-022 rst=1: state IDLE, din=0, wr_addr=0, rd_addr=0, rd_addr_flag=0, rx_valid=0, tx_valid=0, dout=0, MISO=0.
REQ-023 RAM1 contents are not reset.
REQ-024 rst mid-frame aborts frame with no RAM write.

Configuration
REQ-025 Macro SPI_ADDR_AUTOINC_EN defined: after each cmd-01 write wr_addr increments, after each cmd-11 read rd_addr increments and rd_addr_flag stays 1, both modulo 256 (0xFF wraps to 0x00).
REQ-026 Macro undefined: addresses change only via cmds 00/10; cmd 11 clears rd_addr_flag.

Verification
REQ-027 Reset: rst=1 two cycles -> MISO=0, state IDLE, wr_addr=rd_addr=0.
REQ-028 Frame 00_3C then 01_A5 -> RAM1[0x3C]=0xA5, other locations unchanged.
REQ-029 Preload RAM1[0x10]=0x5A; frame 10_10 then 11_xx with SS_n held 19 cycles -> MISO serial 0,1,0,1,1,0,1,0.
REQ-030 SS_n raised after 5 bits of 01_FF frame -> no RAM write, next frame decodes normally.
REQ-031 Frame 11_xx with rd_addr_flag=0 -> FSM takes READ_ADD path, MISO stays 0.
REQ-032 With SPI_ADDR_AUTOINC_EN: wr_addr=0xFF, two 01 frames 0x11,0x22 -> RAM1[0xFF]=0x11, RAM1[0x00]=0x22.
